alarm_controller_mc: RTL and testbench
======================================

# alarm_controller_mc

Multi-channel successor to the single-sensor alarm controller. Accepts NUM_CH parallel distance readings, debounces each against a programmable trip threshold, and runs an arm/exit-delay/armed/alarm state machine. In ALARM it drives the Sound stream: a square wave whose pitch rises as the nearest tripped object gets closer. It sits between the sensor front-ends and the audio DAC path; the I2C control path stays outside this block.

## Interface
- NUM_CH, 2, number of distance channels (1..8)
- DIST_W, 8, distance width in bits
- DEBOUNCE, 4, consecutive below-threshold valid samples required to trip a channel (>=1)
- ARM_DELAY, 1000, exit-delay cycles spent in ARMING
- TONE_HALF_MIN, 16, base tone half-period in cycles (>=1)
- REARM_TIMEOUT, 5000, quiet cycles before auto-rearm (used only with AUTO_REARM_EN)

Ports:
- CLK  in  1  system clock; everything in this block is clocked on its rising edge
- RST  in  1  synchronous, active-high reset
- Distance  in  NUM_CH*DIST_W  packed distances; channel i is at [i*DIST_W +: DIST_W]
- Dist_Valid  in  NUM_CH  per-channel sample strobe; one sample per high cycle
- Threshold  in  DIST_W  trip threshold; a sample trips when it is strictly less than Threshold
- Arm  in  1  arm request pulse
- Disarm  in  1  disarm request pulse
- Sound  out  1  alarm audio bit stream
- Alarm_Active  out  1  high while in ALARM
- Trip_Ch  out  NUM_CH  sticky mask of tripped channels
- State  out  2  0 DISARMED, 1 ARMING, 2 ARMED, 3 ALARM

## Operation
- All outputs are registered. Reset values:
  - State=DISARMED
  - Sound=0, Alarm_Active=0, Trip_Ch=0
  - Debounce counters=0
  - Latched distances = all ones
  - Tone and delay counters = 0
- Per channel:
  - On Dist_Valid[i], latch Distance[i] in every state.
  - Debounce counter[i] updates only in ARMED and ALARM, and only on valid samples.
    - Sample < Threshold: increment, saturating at DEBOUNCE.
    - Otherwise: clear.
  - A counter reaching DEBOUNCE sets Trip_Ch[i].
- State transitions:
  - DISARMED -> ARMING on Arm. Entry clears Trip_Ch and all debounce counters.
  - ARMING: counts ARM_DELAY cycles, then goes to ARMED. Debounce counters are held at 0.
  - ARMED -> ALARM on the cycle any Trip_Ch bit sets.
  - ALARM: further channels can still set their Trip_Ch bits.
- Disarm in any state -> DISARMED on the next cycle.
  - Sound and Alarm_Active go to 0; debounce counters clear.
  - Trip_Ch is retained for readout.
- Arm outside DISARMED is ignored. When Arm and Disarm are high together, Disarm wins.
- Tone generation:
  - On entry to ALARM, Sound goes to 1.
  - Each level is held for exactly P = TONE_HALF_MIN + dmin cycles, then Sound toggles.
  - dmin is the minimum latched distance over channels with Trip_Ch set. It is sampled at each toggle and at entry.
  - The tone counter is wide enough for TONE_HALF_MIN + 2^DIST_W - 1.
  - Sound is 0 in every state except ALARM.

## Timing
- Latency from a valid sample to its latched distance: 1 cycle.
- Latency from the DEBOUNCE-th qualifying sample to Trip_Ch set and State=ALARM: 1 cycle. Sound=1 and Alarm_Active=1 in that same cycle.
- ARMING lasts exactly ARM_DELAY cycles, counted from the first cycle State reads 1.
- Disarm, or RST, takes effect on the first edge where it is sampled high. This holds mid-ARMING and mid-tone.
- A channel that stops asserting Dist_Valid keeps its counter and latched value.

## Configuration
- AUTO_REARM_EN defined: in ALARM, a quiet counter tracks the alarm condition.
  - A cycle is quiet when every latched distance is >= Threshold.
  - The counter increments on quiet cycles and clears on any non-quiet cycle.
  - After REARM_TIMEOUT consecutive quiet cycles: State -> ARMED, Sound=0, Alarm_Active=0.
  - Debounce counters clear on this transition; Trip_Ch is retained.
- AUTO_REARM_EN undefined: ALARM exits only via Disarm or RST. No quiet-counter logic is synthesised.

## Test plan
- Reset and idle: RST high for 2 cycles -> State=0, Sound=0, Trip_Ch=0. Arm pulse -> State=1 for 1000 cycles, then State=2.
- Debounce (NUM_CH=2, Threshold=50, ARMED): ch1 valid samples 40,40,40,60,40,40,40,40 -> no trip until the 4th consecutive 40. ALARM, Trip_Ch=2'b10 one cycle after the last sample.
- Tone pitch (ALARM, ch0 tripped, latched distance 10): Sound holds each level for 26 cycles. A new tripped ch1 value of 4 -> 20-cycle levels from the next toggle.
- Arm and Disarm in the same cycle while DISARMED -> stays DISARMED. Disarm mid-ALARM -> next cycle State=0, Sound=0, Trip_Ch unchanged.
- Arm during ARMING and during ALARM -> no effect; the ARMING count is not restarted.
- AUTO_REARM_EN (REARM_TIMEOUT=5000): after a trip, all distances held at 200 -> State=2 after 5000 quiet cycles. A sample of 30 at cycle 4000 restarts the count.

Source files
------------

// File: rtl/alarm_controller_mc.sv
// alarm_controller_mc: NUM_CH debounced distance trips driving an
// arm / exit-delay / armed / alarm FSM and a distance-pitched tone.
// In : CLK, RST (sync, active high), Distance, Dist_Valid, Threshold,
//      Arm, Disarm.
// Out: Sound, Alarm_Active, Trip_Ch, State.
// Macro AUTO_REARM_EN: ALARM returns to ARMED after REARM_TIMEOUT quiet cycles.
module alarm_controller_mc #(
  parameter int NUM_CH        = 2,
  parameter int DIST_W        = 8,
  parameter int DEBOUNCE      = 4,
  parameter int ARM_DELAY     = 1000,
  parameter int TONE_HALF_MIN = 16,
  parameter int REARM_TIMEOUT = 5000
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_CH*DIST_W-1:0] Distance,
  input  logic [NUM_CH-1:0]        Dist_Valid,
  input  logic [DIST_W-1:0]        Threshold,
  input  logic                     Arm,
  input  logic                     Disarm,
  output logic                     Sound,
  output logic                     Alarm_Active,
  output logic [NUM_CH-1:0]        Trip_Ch,
  output logic [1:0]               State
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam int AW = (ARM_DELAY > 1) ? $clog2(ARM_DELAY) : 1;
  localparam int TW = $clog2(TONE_HALF_MIN + (1 << DIST_W));
  localparam logic [CW-1:0] DB_MAX    = CW'(DEBOUNCE);
  localparam logic [AW-1:0] ARM_LAST  = AW'(ARM_DELAY - 1);
  localparam logic [TW-1:0] TONE_BASE = TW'(TONE_HALF_MIN);

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMING   = 2'd1,
    ARMED    = 2'd2,
    ALARM    = 2'd3
  } state_t;

  state_t            st_q, st_d;
  logic [DIST_W-1:0] dist_q  [NUM_CH];
  logic [DIST_W-1:0] dist_d  [NUM_CH];
  logic [CW-1:0]     cnt_q   [NUM_CH];
  logic [CW-1:0]     cnt_upd [NUM_CH];
  logic [CW-1:0]     cnt_d   [NUM_CH];
  logic [NUM_CH-1:0] hit, trip_d;
  logic [AW-1:0]     dcnt_q, dcnt_d;
  logic [TW-1:0]     tcnt_q, tcnt_d, per_q, per_d;
  logic [DIST_W-1:0] dmin;
  logic              sound_d, live, arm_done, tone_end, rearm;

  assign live  = (st_q == ARMED) || (st_q == ALARM);
  assign State = st_q;

  // Sample latch and raw debounce update; hit feeds the FSM.
  always_comb begin : sample_path
    for (int i = 0; i < NUM_CH; i++) begin
      dist_d[i]  = Dist_Valid[i] ? Distance[i*DIST_W +: DIST_W] : dist_q[i];
      cnt_upd[i] = cnt_q[i];
      if (live && Dist_Valid[i]) begin
        if (Distance[i*DIST_W +: DIST_W] < Threshold)
          cnt_upd[i] = (cnt_q[i] == DB_MAX) ? cnt_q[i] : cnt_q[i] + CW'(1);
        else
          cnt_upd[i] = '0;
      end
      hit[i] = (cnt_upd[i] == DB_MAX);
    end
  end

`ifdef AUTO_REARM_EN
  localparam int QW = $clog2(REARM_TIMEOUT + 1);
  localparam logic [QW-1:0] Q_LAST = QW'(REARM_TIMEOUT - 1);

  logic [QW-1:0] qcnt_q, qcnt_d;
  logic          quiet;

  always_comb begin : quiet_path
    quiet = 1'b1;
    for (int i = 0; i < NUM_CH; i++)
      if (dist_q[i] < Threshold) quiet = 1'b0;
    rearm  = (st_q == ALARM) && quiet && (qcnt_q == Q_LAST);
    qcnt_d = '0;
    if ((st_q == ALARM) && quiet && !rearm)
      qcnt_d = qcnt_q + QW'(1);
  end

  always_ff @(posedge CLK) begin : quiet_reg
    if (RST) qcnt_q <= '0;
    else     qcnt_q <= qcnt_d;
  end
`else
  // Timeout has no meaning here; constant-false keeps the parameter referenced.
  assign rearm = (REARM_TIMEOUT < 0);
`endif

  always_ff @(posedge CLK) begin : state_reg
    if (RST) st_q <= DISARMED;
    else     st_q <= st_d;
  end

  always_comb begin : next_state
    arm_done = (dcnt_q == ARM_LAST);
    st_d     = st_q;
    if (Disarm) begin
      st_d = DISARMED;
    end else begin
      unique case (st_q)
        DISARMED: if (Arm)      st_d = ARMING;
        ARMING:   if (arm_done) st_d = ARMED;
        ARMED:    if (|hit)     st_d = ALARM;
        ALARM:    if (rearm)    st_d = ARMED;
        default:                st_d = DISARMED;
      endcase
    end
  end

  always_comb begin : outputs
    dcnt_d = ((st_q == ARMING) && !arm_done) ? dcnt_q + AW'(1) : '0;
    for (int i = 0; i < NUM_CH; i++)
      cnt_d[i] = (live && (st_d == ARMED || st_d == ALARM) && !rearm)
                 ? cnt_upd[i] : '0;
    if ((st_q == DISARMED) && (st_d == ARMING)) trip_d = '0;
    else if (live && !Disarm)                   trip_d = Trip_Ch | hit;
    else                                        trip_d = Trip_Ch;
    // Pitch follows the post-edge view so entry sees the tripping sample.
    dmin = '1;
    for (int i = 0; i < NUM_CH; i++)
      if (trip_d[i] && (dist_d[i] < dmin)) dmin = dist_d[i];
    tone_end = (tcnt_q == per_q - TW'(1));
    sound_d  = 1'b0;
    tcnt_d   = '0;
    per_d    = per_q;
    if (st_d == ALARM) begin
      if ((st_q != ALARM) || tone_end) begin
        sound_d = (st_q != ALARM) ? 1'b1 : ~Sound;
        per_d   = TONE_BASE + TW'(dmin);
      end else begin
        sound_d = Sound;
        tcnt_d  = tcnt_q + TW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin : data_reg
    if (RST) begin
      for (int i = 0; i < NUM_CH; i++) begin
        dist_q[i] <= '1;
        cnt_q[i]  <= '0;
      end
      Trip_Ch      <= '0;
      dcnt_q       <= '0;
      tcnt_q       <= '0;
      per_q        <= '0;
      Sound        <= 1'b0;
      Alarm_Active <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        dist_q[i] <= dist_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      Trip_Ch      <= trip_d;
      dcnt_q       <= dcnt_d;
      tcnt_q       <= tcnt_d;
      per_q        <= per_d;
      Sound        <= sound_d;
      Alarm_Active <= (st_d == ALARM);
    end
  end

endmodule

// File: tb/tb_alarm_controller_mc.sv
// tb_alarm_controller_mc: directed + random stimulus against a
// cycle-level behavioural model of the alarm controller.
module tb_alarm_controller_mc;

  localparam int NCH  = 2;
  localparam int DW   = 8;
  localparam int DEB  = 4;
  localparam int ARMD = 1000;
  localparam int THM  = 16;
  localparam int RTO  = 5000;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic [NCH*DW-1:0] Distance = {8'd200, 8'd200};
  logic [NCH-1:0]    Dist_Valid = '0;
  logic [DW-1:0]     Threshold = 8'd50;
  logic              Arm = 1'b0;
  logic              Disarm = 1'b0;
  logic              Sound, Alarm_Active;
  logic [NCH-1:0]    Trip_Ch;
  logic [1:0]        State;

  always #5 CLK = ~CLK;

  alarm_controller_mc #(
    .NUM_CH(NCH), .DIST_W(DW), .DEBOUNCE(DEB), .ARM_DELAY(ARMD),
    .TONE_HALF_MIN(THM), .REARM_TIMEOUT(RTO)
  ) dut (
    .CLK(CLK), .RST(RST), .Distance(Distance), .Dist_Valid(Dist_Valid),
    .Threshold(Threshold), .Arm(Arm), .Disarm(Disarm), .Sound(Sound),
    .Alarm_Active(Alarm_Active), .Trip_Ch(Trip_Ch), .State(State)
  );

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Model: ms 0 idle, 1 exit delay, 2 armed, 3 alarm.
  int             ms, marm, mq, mheld, mlen;
  int             mdist [NCH];
  int             mdeb  [NCH];
  int             nd    [NCH];
  logic [NCH-1:0] mtrip;
  logic           msnd;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int mdmin();
    int m = 255;
    for (int i = 0; i < NCH; i++)
      if (mtrip[i] && nd[i] < m) m = nd[i];
    return m;
  endfunction

  task automatic tone_adv();
    if (mheld == mlen) begin
      msnd  = ~msnd;
      mheld = 1;
      mlen  = THM + mdmin();
    end else begin
      mheld++;
    end
  endtask

  task automatic model_step();
    logic newt, quiet;
    int   s;
    if (RST) begin
      ms = 0; marm = 0; mq = 0; mheld = 0; mlen = 0;
      msnd = 1'b0; mtrip = '0;
      for (int i = 0; i < NCH; i++) begin
        mdist[i] = 255; mdeb[i] = 0;
      end
      return;
    end
    for (int i = 0; i < NCH; i++)
      nd[i] = Dist_Valid[i] ? int'(Distance[i*DW +: DW]) : mdist[i];
    if (Disarm) begin
      ms = 0; msnd = 1'b0;
      for (int i = 0; i < NCH; i++) mdeb[i] = 0;
    end else if (ms == 0) begin
      if (Arm) begin
        ms = 1; marm = 1; mtrip = '0;
        for (int i = 0; i < NCH; i++) mdeb[i] = 0;
      end
    end else if (ms == 1) begin
      if (marm == ARMD) ms = 2;
      else marm++;
    end else begin
      newt  = 1'b0;
      quiet = 1'b1;
      for (int i = 0; i < NCH; i++)
        if (mdist[i] < int'(Threshold)) quiet = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        if (Dist_Valid[i]) begin
          s = int'(Distance[i*DW +: DW]);
          if (s < int'(Threshold)) begin
            if (mdeb[i] < DEB) begin
              mdeb[i]++;
              if (mdeb[i] == DEB) begin
                newt = 1'b1; mtrip[i] = 1'b1;
              end
            end
          end else begin
            mdeb[i] = 0;
          end
        end
      end
      if (ms == 2) begin
        if (newt) begin
          ms = 3; msnd = 1'b1; mheld = 1; mq = 0;
          mlen = THM + mdmin();
        end
      end else begin
`ifdef AUTO_REARM_EN
        if (quiet) mq++;
        else       mq = 0;
        if (mq == RTO) begin
          ms = 2; msnd = 1'b0; mq = 0;
          for (int i = 0; i < NCH; i++) mdeb[i] = 0;
        end else begin
          tone_adv();
        end
`else
        tone_adv();
`endif
      end
    end
    for (int i = 0; i < NCH; i++) mdist[i] = nd[i];
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
    chk("cyc_state", 32'(State), 32'(ms));
    chk("cyc_sound", 32'(Sound), 32'(msnd));
    chk("cyc_alarm", 32'(Alarm_Active), 32'(ms == 3));
    chk("cyc_trip", 32'(Trip_Ch), 32'(mtrip));
  endtask

  task automatic measure(input int want, input string tag, input bit inj);
    logic s;
    int   n;
    s = Sound;
    n = 0;
    while (Sound === s && n < 1000) begin
      if (inj && n < 4) begin
        Dist_Valid = 2'b10;
        Distance[15:8] = 8'd4;
      end
      tick();
      Dist_Valid = '0;
      n++;
    end
    chk(tag, 32'(n), 32'(want));
  endtask

  task automatic do_arm();
    Arm = 1'b1; tick(); Arm = 1'b0;
    chk("arm_enter", 32'(State), 32'd1);
    chk("arm_clr_trip", 32'(Trip_Ch), 32'd0);
    repeat (ARMD) tick();
    chk("arm_done", 32'(State), 32'd2);
  endtask

  task automatic trip_ch0();
    Dist_Valid = 2'b01;
    Distance[7:0] = 8'd10;
    repeat (DEB) tick();
    Dist_Valid = '0;
    chk("trip0_state", 32'(State), 32'd3);
    chk("trip0_bit", 32'(Trip_Ch[0]), 32'd1);
    chk("trip0_sound", 32'(Sound), 32'd1);
  endtask

  initial begin
    int n;
    int smp [8];
    smp = '{40, 40, 40, 60, 40, 40, 40, 40};

    // Reset and idle
    RST = 1'b1;
    tick(); tick();
    RST = 1'b0;
    chk("rst_state", 32'(State), 32'd0);
    chk("rst_sound", 32'(Sound), 32'd0);
    chk("rst_trip", 32'(Trip_Ch), 32'd0);
    chk("rst_alarm", 32'(Alarm_Active), 32'd0);

    // Exit delay length, with an ignored Arm mid-way
    Arm = 1'b1; tick(); Arm = 1'b0;
    n = 1;
    while (State == 2'd1 && n < 3000) begin
      if (n == 500) Arm = 1'b1;
      tick();
      Arm = 1'b0;
      if (State == 2'd1) n++;
    end
    chk("arming_len", 32'(n), 32'd1000);
    chk("armed", 32'(State), 32'd2);

    // Debounce on ch1, 60 breaks the run
    for (int k = 0; k < 8; k++) begin
      Dist_Valid = 2'b10;
      Distance[15:8] = 8'(smp[k]);
      tick();
      Dist_Valid = '0;
      if (k < 7) begin
        chk("deb_no_trip", 32'(Trip_Ch), 32'd0);
        tick();
      end
    end
    chk("deb_state", 32'(State), 32'd3);
    chk("deb_trip", 32'(Trip_Ch), 32'd2);
    chk("deb_sound", 32'(Sound), 32'd1);
    chk("deb_alarm", 32'(Alarm_Active), 32'd1);
    measure(56, "tone_d40", 1'b0);

    // Disarm mid-alarm keeps Trip_Ch
    Disarm = 1'b1; tick(); Disarm = 1'b0;
    chk("dis_state", 32'(State), 32'd0);
    chk("dis_sound", 32'(Sound), 32'd0);
    chk("dis_trip", 32'(Trip_Ch), 32'd2);

    // Arm and Disarm together
    Arm = 1'b1; Disarm = 1'b1; tick(); Arm = 1'b0; Disarm = 1'b0;
    chk("arm_dis_same", 32'(State), 32'd0);
    chk("arm_dis_trip", 32'(Trip_Ch), 32'd2);

    // Tone pitch
    do_arm();
    trip_ch0();
    measure(26, "tone_d10_hi", 1'b0);
    measure(26, "tone_d10_lo", 1'b1);
    chk("tone_trip2", 32'(Trip_Ch), 32'd3);
    measure(20, "tone_d4_hi", 1'b0);
    measure(20, "tone_d4_lo", 1'b0);
    Arm = 1'b1; tick(); Arm = 1'b0;
    chk("arm_in_alarm", 32'(State), 32'd3);
    Disarm = 1'b1; tick(); Disarm = 1'b0;
    chk("dis2_state", 32'(State), 32'd0);
    chk("dis2_sound", 32'(Sound), 32'd0);
    chk("dis2_trip", 32'(Trip_Ch), 32'd3);

    // Quiet behaviour in ALARM
    do_arm();
    trip_ch0();
    Dist_Valid = 2'b11;
    Distance = {8'd200, 8'd200};
    tick();
    Dist_Valid = '0;
`ifdef AUTO_REARM_EN
    repeat (3999) tick();
    Dist_Valid = 2'b10; Distance[15:8] = 8'd30; tick();
    Distance[15:8] = 8'd200; tick();
    Dist_Valid = '0;
    repeat (4999) tick();
    chk("rearm_wait", 32'(State), 32'd3);
    tick();
    chk("rearm_state", 32'(State), 32'd2);
    chk("rearm_sound", 32'(Sound), 32'd0);
    chk("rearm_alarm", 32'(Alarm_Active), 32'd0);
    chk("rearm_trip", 32'(Trip_Ch), 32'd1);
`else
    repeat (6000) tick();
    chk("no_rearm", 32'(State), 32'd3);
`endif
    Disarm = 1'b1; tick(); Disarm = 1'b0;

    // Random traffic against the model
    for (int r = 0; r < 3; r++) begin
      Threshold = 8'($urandom_range(20, 120));
      for (int c = 0; c < 2500; c++) begin
        Dist_Valid = 2'($urandom_range(0, 3));
        for (int i = 0; i < NCH; i++)
          Distance[i*DW +: DW] = ($urandom_range(0, 3) != 0)
            ? 8'($urandom_range(0, int'(Threshold) - 1))
            : 8'($urandom_range(0, 255));
        Arm    = ($urandom_range(0, 39) == 0);
        Disarm = (ms == 3) && ($urandom_range(0, 149) == 0);
        tick();
      end
      Arm = 1'b0; Disarm = 1'b0; Dist_Valid = '0;
    end

    // Reset mid-tone
    Threshold = 8'd50;
    Disarm = 1'b1; tick(); Disarm = 1'b0;
    do_arm();
    trip_ch0();
    repeat (7) tick();
    RST = 1'b1; tick(); RST = 1'b0;
    chk("rst2_state", 32'(State), 32'd0);
    chk("rst2_sound", 32'(Sound), 32'd0);
    chk("rst2_trip", 32'(Trip_Ch), 32'd0);
    chk("rst2_alarm", 32'(Alarm_Active), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
